// File: rtl/chk_pkg.sv
// Shared definitions for the response signature checker: state encoding and
// default MISR polynomial/seed.
package chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] DEF_POLY = 8'h1D;
  localparam logic [7:0] DEF_SEED = 8'hFF;

endpackage

// File: rtl/response_signature_checker_misr_step.sv
// One combinational MISR step: shift, conditional polynomial feedback, then
// fold in the zero-extended response word.
module misr_step #(
  parameter int               SIG_W  = 8,
  parameter int               RESP_W = 2,
  parameter logic [SIG_W-1:0] POLY   = 8'h1D
) (
  input  logic [SIG_W-1:0]  i_s,
  input  logic [RESP_W-1:0] i_r,
  output logic [SIG_W-1:0]  o_next
);

  logic [SIG_W-1:0] w_shift;
  logic [SIG_W-1:0] w_fb;

  assign w_shift = {i_s[SIG_W-2:0], 1'b0};
  assign w_fb    = i_s[SIG_W-1] ? POLY : '0;
  assign o_next  = w_shift ^ w_fb ^ SIG_W'(i_r);

endmodule

// File: rtl/response_signature_checker.sv
// Compacts DUT responses into a MISR over one sweep of NUM_VEC vectors and
// reports whether the final signature matches the golden value.
module response_signature_checker
  import chk_pkg::*;
#(
  parameter int               RESP_W  = 2,
  parameter int               NUM_VEC = 16,
  parameter int               CNT_W   = 5,
  parameter int               SIG_W   = 8,
  parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED    = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
  input  logic [SIG_W-1:0]  exp_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  sig,
  output logic [CNT_W-1:0]  vec_cnt
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUM_VEC - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;
  logic             w_load;
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_next;
  logic [CNT_W-1:0] r_vec_cnt;
  logic             r_pass;

  misr_step #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (POLY)
  ) u_misr_step (
    .i_s    (r_sig),
    .i_r    (resp),
    .o_next (w_sig_next)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next_state = S_COLLECT;
          w_load       = 1'b1;
        end
      end
      S_COLLECT: begin
        if (resp_valid) begin
          w_accept = 1'b1;
          if (r_vec_cnt == LP_LAST) w_next_state = S_COMPARE;
        end
      end
      S_COMPARE: w_next_state = S_DONE;
      default:   w_next_state = S_IDLE;
    endcase
    // Abort outranks start and discards any partial sweep.
    if (abort) begin
      w_next_state = S_IDLE;
      w_accept     = 1'b0;
      w_load       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort || w_load) begin
      r_sig     <= SEED;
      r_vec_cnt <= '0;
      r_pass    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sig     <= w_sig_next;
        r_vec_cnt <= r_vec_cnt + 1'b1;
      end
      if (r_state == S_COMPARE) r_pass <= (r_sig == exp_sig);
    end
  end

  assign busy    = (r_state == S_COLLECT) || (r_state == S_COMPARE);
  assign done    = (r_state == S_DONE);
  assign pass    = r_pass;
  assign sig     = r_sig;
  assign vec_cnt = r_vec_cnt;

endmodule

// File: tb/tb_response_signature_checker.sv
// Scoreboard bench: a short (2-vector) and a full (16-vector) checker instance
// share one stimulus bus selected by sel16; a monitor checks each sweep result.
module tb_response_signature_checker;

  logic       clk = 1'b0;
  logic       rst, start, abort, resp_valid, sel16;
  logic [1:0] resp;
  logic [7:0] exp_sig;

  logic       b2, d2, p2, b16, d16, p16;
  logic [7:0] s2, s16;
  logic [4:0] c2, c16;

  logic       m_busy, m_done, m_pass;
  logic [7:0] m_sig;
  logic [4:0] m_cnt;

  typedef struct {logic [7:0] sig; int cnt; logic pass;} exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;
  int busy_cycles = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  response_signature_checker #(.NUM_VEC(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start & ~sel16), .abort(abort & ~sel16),
    .resp_valid(resp_valid & ~sel16), .resp(resp), .exp_sig(exp_sig),
    .busy(b2), .done(d2), .pass(p2), .sig(s2), .vec_cnt(c2));

  response_signature_checker #(.NUM_VEC(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start & sel16), .abort(abort & sel16),
    .resp_valid(resp_valid & sel16), .resp(resp), .exp_sig(exp_sig),
    .busy(b16), .done(d16), .pass(p16), .sig(s16), .vec_cnt(c16));

  assign m_busy = sel16 ? b16 : b2;
  assign m_done = sel16 ? d16 : d2;
  assign m_pass = sel16 ? p16 : p2;
  assign m_sig  = sel16 ? s16 : s2;
  assign m_cnt  = sel16 ? c16 : c2;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Result monitor: each rising edge of done retires one expected sweep.
  always @(negedge clk) begin
    if (m_busy) busy_cycles++;
    if (m_done && !prev_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_sig", m_sig, e.sig);
        chk("sb_vec_cnt", m_cnt, e.cnt);
        chk("sb_pass", m_pass, e.pass);
      end
    end
    prev_done = m_done;
  end

  function automatic logic [7:0] model_step(input logic [7:0] s, input logic [1:0] r);
    logic [7:0] n;
    n = {s[6:0], 1'b0};
    if (s[7]) n = n ^ 8'h1D;
    return n ^ {6'b0, r};
  endfunction

  function automatic logic [1:0] sweep_resp(input int i);
    logic [3:0] v;
    v = i[3:0];
    return {v[3] ^ v[2], v[1] & v[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] r);
    resp_valid = 1'b1;
    resp = r;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full 16-vector sweep; optionally pulses start mid-sweep (must be ignored).
  task automatic run_full(input bit mid_start, input bit chk_busy);
    logic [7:0] s;
    s = 8'hFF;
    busy_cycles = 0;
    start_pulse();
    chk("full_start_sig", m_sig, 8'hFF);
    for (int i = 0; i < 16; i++) begin
      if (mid_start && i == 3) begin
        start_pulse();
        chk("mid_start_cnt", m_cnt, 3);
        chk("mid_start_sig", m_sig, s);
      end
      send(sweep_resp(i));
      s = model_step(s, sweep_resp(i));
    end
    chk("full_done_latency0", m_done, 0);
    tick();
    chk("full_done_latency1", m_done, 1);
    if (chk_busy) chk("full_busy_cycles", busy_cycles, 17);
  endtask

  logic [7:0] full_sig;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; resp_valid = 1'b0;
    resp = 2'b00; exp_sig = 8'h00; sel16 = 1'b0;
    full_sig = 8'hFF;
    for (int i = 0; i < 16; i++) full_sig = model_step(full_sig, sweep_resp(i));

    // Reset with resp_valid toggling
    send(2'b11);
    tick();
    chk("rst_sig", s2, 8'hFF);
    chk("rst_vec_cnt", c2, 0);
    chk("rst_busy", b2, 0);
    chk("rst_done", d2, 0);
    chk("rst_pass", p2, 0);
    chk("rst_sig16", s16, 8'hFF);
    rst = 1'b0;
    send(2'b01);
    chk("idle_ignores_valid", m_sig, 8'hFF);

    // Short sweep, matching signature
    exp_sig = 8'hDB;
    q.push_back('{sig: 8'hDB, cnt: 2, pass: 1'b1});
    start_pulse();
    chk("short_busy", m_busy, 1);
    send(2'b01);
    chk("short_sig1", m_sig, 8'hE2);
    chk("short_cnt1", m_cnt, 1);
    send(2'b10);
    chk("short_sig2", m_sig, 8'hDB);
    chk("short_done_latency0", m_done, 0);
    exp_sig = 8'h00;
    chk("short_compare_busy", m_busy, 1);
    exp_sig = 8'hDB;
    tick();
    chk("short_done", m_done, 1);
    exp_sig = 8'h00;
    tick();
    chk("short_pass_held", m_pass, 1);

    // Restart from DONE, mismatching signature, gaps and overrun
    exp_sig = 8'hDA;
    q.push_back('{sig: 8'hDB, cnt: 2, pass: 1'b0});
    start_pulse();
    chk("restart_done_drop", m_done, 0);
    chk("restart_sig", m_sig, 8'hFF);
    chk("restart_pass", m_pass, 0);
    send(2'b01);
    tick(); tick(); tick();
    chk("gap_sig", m_sig, 8'hE2);
    chk("gap_cnt", m_cnt, 1);
    send(2'b10);
    tick();
    chk("gap_done", m_done, 1);
    send(2'b11);
    chk("overrun_sig", m_sig, 8'hDB);
    chk("overrun_cnt", m_cnt, 2);
    chk("overrun_done", m_done, 1);

    // Full sweep on the 16-vector instance
    sel16 = 1'b1;
    exp_sig = full_sig;
    q.push_back('{sig: full_sig, cnt: 16, pass: 1'b1});
    run_full(1'b0, 1'b1);

    // Abort after 5 vectors, then restart with an ignored mid-sweep start
    start_pulse();
    for (int i = 0; i < 5; i++) send(sweep_resp(i));
    chk("pre_abort_cnt", m_cnt, 5);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_sig", m_sig, 8'hFF);
    chk("abort_cnt", m_cnt, 0);
    chk("abort_busy", m_busy, 0);
    chk("abort_done", m_done, 0);
    q.push_back('{sig: full_sig, cnt: 16, pass: 1'b1});
    run_full(1'b1, 1'b0);

    // Second sweep from DONE reproduces the signature
    q.push_back('{sig: full_sig, cnt: 16, pass: 1'b1});
    run_full(1'b0, 1'b1);

    // Mid-sweep reset behaves like abort
    start_pulse();
    send(2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_sig", m_sig, 8'hFF);
    chk("midrst_busy", m_busy, 0);

    tick();
    chk("sb_pending", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
